// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the 8-bit stack processor: opcodes, control FSM states
// and the memory-mapped I/O window at the top of the address space.
package stack_cpu_pkg;

    localparam logic [7:0] OP_PUSHC  = 8'h00;
    localparam logic [7:0] OP_PUSH   = 8'h01;
    localparam logic [7:0] OP_POP    = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h06;
    localparam logic [7:0] OP_SUB    = 8'h07;
    localparam logic [7:0] OP_FINISH = 8'h0F;

    localparam logic [7:0] IO_OUT     = 8'hF8;
    localparam logic [7:0] IO_IN_BASE = 8'hF9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_LOAD,
        ST_PUSH_WR,
        ST_POP_RD,
        ST_POP_WR,
        ST_ALU_T,
        ST_ALU_N,
        ST_ALU_WR,
        ST_HALT,
        ST_ERROR
    } state_t;

    // The stack grows down from spInit, so the occupied depth is the distance below it.
    function automatic logic [7:0] stackDepth(input logic [7:0] spInit, input logic [7:0] sp);
        return spInit - sp;
    endfunction

endpackage

// File: rtl/stack_cpu_ctrl_if.sv
// Single-port memory bus between the control unit (master) and the
// program/data memory (slave); the memory acts on the falling clock edge.
interface stack_cpu_ctrl_if;

    logic [7:0] mem_addr;
    logic       mem_rwN;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_rwN,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rwN,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/stack_cpu_ctrl.sv
// Control unit of the 8-bit stack processor: fetch/decode/execute sequencer that
// owns PC and SP and keeps the operand stack in the shared 256-byte memory.
module stack_cpu_ctrl
    import stack_cpu_pkg::*;
#(
    parameter logic [7:0] SP_INIT     = 8'hEF,
    parameter logic [7:0] STACK_FLOOR = 8'hC0
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    run,
    stack_cpu_ctrl_if.master        mem,
    output logic [7:0]              pc,
    output logic [7:0]              sp,
    output logic                    busy,
    output logic                    halted,
    output logic                    error
);

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] sp_q, sp_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] opr_q, opr_d;
    logic [7:0] tmp_q, tmp_d;

    logic [7:0] depth;
    logic       pushOk;
    logic       popOk;
    logic       aluOk;

    assign depth  = stackDepth(SP_INIT, sp_q);
    assign pushOk = (sp_q >= STACK_FLOOR);
    assign popOk  = (depth >= 8'd1);
    assign aluOk  = (depth >= 8'd2);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            pc_q    <= 8'h00;
            sp_q    <= SP_INIT;
            ir_q    <= 8'h00;
            opr_q   <= 8'h00;
            tmp_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
            tmp_q   <= tmp_d;
        end
    end

    // Every read is captured on the rising edge that leaves the state issuing it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        ir_d    = ir_q;
        opr_d   = opr_q;
        tmp_d   = tmp_q;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = mem.mem_rdata;
                pc_d    = pc_q + 8'd1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                opr_d = mem.mem_rdata;
                if (ir_q inside {OP_PUSHC, OP_PUSH, OP_POP}) begin
                    pc_d = pc_q + 8'd1;
                end
                case (ir_q)
                    OP_PUSHC:       state_d = pushOk ? ST_PUSH_WR : ST_ERROR;
                    OP_PUSH:        state_d = pushOk ? ST_LOAD    : ST_ERROR;
                    OP_POP:         state_d = popOk  ? ST_POP_RD  : ST_ERROR;
                    OP_ADD, OP_SUB: state_d = aluOk  ? ST_ALU_T   : ST_ERROR;
                    OP_FINISH:      state_d = ST_HALT;
                    default:        state_d = ST_ERROR;
                endcase
            end
            ST_LOAD: begin
                opr_d   = mem.mem_rdata;
                state_d = ST_PUSH_WR;
            end
            ST_PUSH_WR: begin
                sp_d    = sp_q - 8'd1;
                state_d = ST_FETCH;
            end
            ST_POP_RD: begin
                tmp_d   = mem.mem_rdata;
                sp_d    = sp_q + 8'd1;
                state_d = ST_POP_WR;
            end
            ST_POP_WR: begin
                state_d = ST_FETCH;
            end
            ST_ALU_T: begin
                tmp_d   = mem.mem_rdata;
                state_d = ST_ALU_N;
            end
            ST_ALU_N: begin
                // TMP holds the top entry, so SUB yields top minus second.
                tmp_d   = (ir_q == OP_SUB) ? (tmp_q - mem.mem_rdata) : (tmp_q + mem.mem_rdata);
                sp_d    = sp_q + 8'd1;
                state_d = ST_ALU_WR;
            end
            ST_ALU_WR: begin
                state_d = ST_FETCH;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Bus outputs depend only on state and registers so an async reset drops a pending write at once.
    always_comb begin
        mem.mem_addr  = pc_q;
        mem.mem_rwN   = 1'b1;
        mem.mem_wdata = 8'h00;

        case (state_q)
            ST_LOAD: begin
                mem.mem_addr = opr_q;
            end
            ST_PUSH_WR: begin
                mem.mem_addr  = sp_q;
                mem.mem_rwN   = 1'b0;
                mem.mem_wdata = opr_q;
            end
            ST_POP_RD, ST_ALU_T: begin
                mem.mem_addr = sp_q + 8'd1;
            end
            ST_POP_WR: begin
                mem.mem_addr  = opr_q;
                mem.mem_rwN   = 1'b0;
                mem.mem_wdata = tmp_q;
            end
            ST_ALU_N: begin
                mem.mem_addr = sp_q + 8'd2;
            end
            ST_ALU_WR: begin
                mem.mem_addr  = sp_q + 8'd1;
                mem.mem_rwN   = 1'b0;
                mem.mem_wdata = tmp_q;
            end
            default: begin
                mem.mem_addr = pc_q;
            end
        endcase
    end

    assign pc     = pc_q;
    assign sp     = sp_q;
    assign busy   = !(state_q inside {ST_IDLE, ST_HALT, ST_ERROR});
    assign halted = (state_q == ST_HALT) || (state_q == ST_ERROR);
    assign error  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_stack_cpu_ctrl.sv
// Bench for stack_cpu_ctrl: directed scenarios plus random programs compared with an
// instruction-level model of the stack machine and its memory-mapped I/O.
module tb_stack_cpu_ctrl;
    import stack_cpu_pkg::*;

    localparam logic [7:0] SP_INIT     = 8'hEF;
    localparam logic [7:0] FLOOR_DEF   = 8'hC0;
    localparam logic [7:0] FLOOR_HI    = 8'hEE;
    localparam int         CYCLE_LIMIT = 600;

    logic clk = 1'b0;
    logic resetN;
    logic runReq;
    logic sel;
    logic loadReq;
    logic run0, run1;
    logic [7:0] pc0, sp0, pc1, sp1;
    logic busy0, halted0, error0, busy1, halted1, error1;

    logic [7:0] img    [256];
    logic [7:0] mem0   [256];
    logic [7:0] mem1   [256];
    logic [7:0] refMem [256];
    logic [7:0] inport [7];
    int wc0 = 0;
    int wc1 = 0;

    logic [7:0] refPc, refSp;
    int refCycles, refWrites;
    bit refErr;

    int checks = 0;
    int errors = 0;

    stack_cpu_ctrl_if m0 ();
    stack_cpu_ctrl_if m1 ();

    stack_cpu_ctrl #(.SP_INIT(SP_INIT), .STACK_FLOOR(FLOOR_DEF)) dut (
        .clk(clk), .resetN(resetN), .run(run0), .mem(m0),
        .pc(pc0), .sp(sp0), .busy(busy0), .halted(halted0), .error(error0)
    );

    stack_cpu_ctrl #(.SP_INIT(SP_INIT), .STACK_FLOOR(FLOOR_HI)) dutFloor (
        .clk(clk), .resetN(resetN), .run(run1), .mem(m1),
        .pc(pc1), .sp(sp1), .busy(busy1), .halted(halted1), .error(error1)
    );

    always #5 clk = ~clk;

    assign run0 = runReq & ~sel;
    assign run1 = runReq & sel;

    // Falling-edge memory for both instances: F8 and below store, F9-FF are input ports.
    always @(negedge clk) begin
        if (loadReq) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] = img[i];
                mem1[i] = img[i];
            end
        end else begin
            if (m0.mem_rwN == 1'b0) begin
                wc0++;
                if (m0.mem_addr < IO_IN_BASE) mem0[m0.mem_addr] = m0.mem_wdata;
            end
            if (m1.mem_rwN == 1'b0) begin
                wc1++;
                if (m1.mem_addr < IO_IN_BASE) mem1[m1.mem_addr] = m1.mem_wdata;
            end
        end
        m0.mem_rdata = (m0.mem_addr >= IO_IN_BASE) ? inport[3'(m0.mem_addr - IO_IN_BASE)] : mem0[m0.mem_addr];
        m1.mem_rdata = (m1.mem_addr >= IO_IN_BASE) ? inport[3'(m1.mem_addr - IO_IN_BASE)] : mem1[m1.mem_addr];
    end

    function automatic logic [7:0] refRd(input logic [7:0] a);
        return (a >= IO_IN_BASE) ? inport[3'(a - IO_IN_BASE)] : refMem[a];
    endfunction

    task automatic refWr(input logic [7:0] a, input logic [7:0] v);
        refWrites++;
        if (a < IO_IN_BASE) refMem[a] = v;
    endtask

    // Executes the program one instruction at a time with the ISA's stack rules and cycle costs.
    task automatic modelRun(input logic [7:0] floor);
        logic [7:0] op, arg, t, n;
        int depth;
        bit done;
        refPc = 8'h00; refSp = SP_INIT; refCycles = 0; refWrites = 0; refErr = 0; done = 0;
        for (int step = 0; step < 200 && !done; step++) begin
            op = refRd(refPc);
            refPc++;
            depth = int'(SP_INIT) - int'(refSp);
            arg = 8'h00;
            if (op == OP_PUSHC || op == OP_PUSH || op == OP_POP) begin
                arg = refRd(refPc);
                refPc++;
            end
            if (op == OP_PUSHC || op == OP_PUSH) begin
                if (refSp < floor) begin
                    refErr = 1; done = 1; refCycles += 2;
                end else begin
                    t = (op == OP_PUSHC) ? arg : refRd(arg);
                    refWr(refSp, t);
                    refSp--;
                    refCycles += (op == OP_PUSHC) ? 3 : 4;
                end
            end else if (op == OP_POP) begin
                if (depth < 1) begin
                    refErr = 1; done = 1; refCycles += 2;
                end else begin
                    t = refRd(refSp + 8'd1);
                    refSp++;
                    refWr(arg, t);
                    refCycles += 4;
                end
            end else if (op == OP_ADD || op == OP_SUB) begin
                if (depth < 2) begin
                    refErr = 1; done = 1; refCycles += 2;
                end else begin
                    t = refRd(refSp + 8'd1);
                    n = refRd(refSp + 8'd2);
                    refSp = refSp + 8'd2;
                    refWr(refSp, (op == OP_ADD) ? (t + n) : (t - n));
                    refSp--;
                    refCycles += 5;
                end
            end else if (op == OP_FINISH) begin
                done = 1; refCycles += 2;
            end else begin
                refErr = 1; done = 1; refCycles += 2;
            end
        end
    endtask

    task automatic applyReset();
        resetN  = 1'b0;
        runReq  = 1'b0;
        repeat (2) @(posedge clk);
        loadReq = 1'b1;
        @(negedge clk);
        #1 loadReq = 1'b0;
        for (int i = 0; i < 256; i++) refMem[i] = img[i];
        @(negedge clk);
        resetN = 1'b1;
        #1;
    endtask

    task automatic runDut(output int cyc, output int writes);
        int w0;
        w0 = sel ? wc1 : wc0;
        @(negedge clk);
        runReq = 1'b1;
        @(posedge clk);
        #1 runReq = 1'b0;
        cyc = 0;
        while (!(sel ? halted1 : halted0) && cyc < CYCLE_LIMIT) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        writes = (sel ? wc1 : wc0) - w0;
    endtask

    task automatic loadBoot();
        logic [7:0] prog [18] = '{8'h00, 8'h0C, 8'h00, 8'h17, 8'h01, 8'hF9, 8'h06, 8'h02, 8'hF0,
                                  8'h01, 8'hF0, 8'h01, 8'hF0, 8'h06, 8'h07, 8'h02, 8'hF8, 8'h0F};
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        for (int i = 0; i < 18; i++) img[i] = prog[i];
        for (int i = 0; i < 7; i++) inport[i] = 8'($urandom);
        inport[0] = 8'd5;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        sel = 1'b0;
        applyReset();
        checks++;
        if (pc0 !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 00", pc0); end
        checks++;
        if (sp0 !== SP_INIT) begin errors++; $display("[TB] FAIL reset_sp: got %h expected %h", sp0, SP_INIT); end
        checks++;
        if ({m0.mem_addr, m0.mem_rwN, m0.mem_wdata} !== {8'h00, 1'b1, 8'h00})
            begin errors++; $display("[TB] FAIL reset_bus: got addr=%h rwN=%b wdata=%h expected 00/1/00", m0.mem_addr, m0.mem_rwN, m0.mem_wdata); end
        checks++;
        if ({busy0, halted0, error0} !== 3'b000)
            begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy0, halted0, error0}); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b0 || pc0 !== 8'h00)
            begin errors++; $display("[TB] FAIL idle_hold: got busy=%b pc=%h expected 0/00", busy0, pc0); end
    endtask

    task automatic test_boot();
        int cyc, wr;
        loadBoot();
        sel = 1'b0;
        applyReset();
        modelRun(FLOOR_DEF);
        runDut(cyc, wr);
        checks++;
        if (cyc !== 43) begin errors++; $display("[TB] FAIL boot_cycles: got %0d expected 43", cyc); end
        checks++;
        if (cyc !== refCycles) begin errors++; $display("[TB] FAIL boot_model_cycles: got %0d expected %0d", cyc, refCycles); end
        checks++;
        if (mem0[8'hF8] !== 8'h2C) begin errors++; $display("[TB] FAIL boot_out: got %h expected 2C", mem0[8'hF8]); end
        checks++;
        if (mem0[8'hF0] !== 8'h1C) begin errors++; $display("[TB] FAIL boot_f0: got %h expected 1C", mem0[8'hF0]); end
        checks++;
        if (sp0 !== SP_INIT || error0 !== 1'b0 || halted0 !== 1'b1 || busy0 !== 1'b0)
            begin errors++; $display("[TB] FAIL boot_final: got sp=%h err=%b halt=%b busy=%b expected %h/0/1/0", sp0, error0, halted0, busy0, SP_INIT); end
        checks++;
        if (pc0 !== refPc || wr !== refWrites)
            begin errors++; $display("[TB] FAIL boot_pc_writes: got pc=%h writes=%0d expected %h/%0d", pc0, wr, refPc, refWrites); end
    endtask

    task automatic test_run_pulse();
        @(negedge clk);
        runReq = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (halted0 !== 1'b1 || busy0 !== 1'b0 || pc0 !== 8'h12 || m0.mem_rwN !== 1'b1)
            begin errors++; $display("[TB] FAIL halt_ignores_run: got halt=%b busy=%b pc=%h rwN=%b expected 1/0/12/1", halted0, busy0, pc0, m0.mem_rwN); end
        runReq = 1'b0;
    endtask

    task automatic test_empty_add();
        int cyc, wr;
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        img[0] = OP_PUSHC; img[1] = 8'h03; img[2] = OP_ADD; img[3] = OP_FINISH;
        sel = 1'b0;
        applyReset();
        modelRun(FLOOR_DEF);
        runDut(cyc, wr);
        checks++;
        if (error0 !== 1'b1 || cyc !== 5 || cyc !== refCycles)
            begin errors++; $display("[TB] FAIL empty_add_err: got err=%b cycles=%0d expected 1/5", error0, cyc); end
        checks++;
        if (wr !== 1 || sp0 !== 8'hEE || pc0 !== 8'h03)
            begin errors++; $display("[TB] FAIL empty_add_state: got writes=%0d sp=%h pc=%h expected 1/EE/03", wr, sp0, pc0); end
    endtask

    task automatic test_bad_opcode();
        int cyc, wr;
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        img[0] = 8'h05;
        sel = 1'b0;
        applyReset();
        runDut(cyc, wr);
        checks++;
        if (cyc !== 2 || pc0 !== 8'h01 || wr !== 0)
            begin errors++; $display("[TB] FAIL bad_op_timing: got cycles=%0d pc=%h writes=%0d expected 2/01/0", cyc, pc0, wr); end
        checks++;
        if ({halted0, error0, busy0} !== 3'b110)
            begin errors++; $display("[TB] FAIL bad_op_flags: got %b expected 110", {halted0, error0, busy0}); end
    endtask

    task automatic test_floor();
        int cyc, wr;
        logic [7:0] keepEd;
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        img[0] = OP_PUSHC; img[1] = 8'h01; img[2] = OP_PUSHC; img[3] = 8'h02;
        img[4] = OP_PUSHC; img[5] = 8'h03; img[6] = OP_FINISH;
        keepEd = img[8'hED];
        sel = 1'b1;
        applyReset();
        runDut(cyc, wr);
        checks++;
        if (error1 !== 1'b1 || sp1 !== 8'hED || cyc !== 8 || pc1 !== 8'h06)
            begin errors++; $display("[TB] FAIL floor_err: got err=%b sp=%h cycles=%0d pc=%h expected 1/ED/8/06", error1, sp1, cyc, pc1); end
        checks++;
        if (wr !== 2 || mem1[8'hEF] !== 8'h01 || mem1[8'hEE] !== 8'h02 || mem1[8'hED] !== keepEd)
            begin errors++; $display("[TB] FAIL floor_mem: got writes=%0d EF=%h EE=%h ED=%h expected 2/01/02/%h", wr, mem1[8'hEF], mem1[8'hEE], mem1[8'hED], keepEd); end
    endtask

    task automatic test_reset_mid();
        int seen, cyc;
        loadBoot();
        sel = 1'b0;
        applyReset();
        @(negedge clk);
        runReq = 1'b1;
        @(posedge clk);
        #1 runReq = 1'b0;
        seen = 0;
        cyc = 0;
        while (seen < 4 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (m0.mem_rwN == 1'b0) seen++;
        end
        checks++;
        if (seen !== 4) begin errors++; $display("[TB] FAIL mid_reach_alu_wr: got %0d writes expected 4", seen); end
        checks++;
        if (m0.mem_addr !== 8'hEE || m0.mem_wdata !== 8'h1C || busy0 !== 1'b1 || mem0[8'hEE] !== 8'h17)
            begin errors++; $display("[TB] FAIL mid_alu_wr: got addr=%h wdata=%h busy=%b old=%h expected EE/1C/1/17", m0.mem_addr, m0.mem_wdata, busy0, mem0[8'hEE]); end
        #1 resetN = 1'b0;
        #1;
        checks++;
        if (m0.mem_rwN !== 1'b1 || busy0 !== 1'b0 || pc0 !== 8'h00 || sp0 !== SP_INIT)
            begin errors++; $display("[TB] FAIL mid_async: got rwN=%b busy=%b pc=%h sp=%h expected 1/0/00/%h", m0.mem_rwN, busy0, pc0, sp0, SP_INIT); end
        @(negedge clk);
        #1;
        checks++;
        if (mem0[8'hEE] !== 8'h17) begin errors++; $display("[TB] FAIL mid_write_suppressed: got %h expected 17", mem0[8'hEE]); end
        resetN = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b0 || halted0 !== 1'b0 || pc0 !== 8'h00 || sp0 !== SP_INIT)
            begin errors++; $display("[TB] FAIL mid_idle_after: got busy=%b halt=%b pc=%h sp=%h expected 0/0/00/%h", busy0, halted0, pc0, sp0, SP_INIT); end
    endtask

    task automatic test_random();
        int cyc, wr, a, d, r, n, bad;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
            for (int i = 0; i < 7; i++) inport[i] = 8'($urandom);
            a = 0;
            d = 0;
            n = int'($urandom_range(4, 20));
            for (int i = 0; i < n; i++) begin
                r = int'($urandom_range(0, 9));
                if (d < 2 && r >= 6 && $urandom_range(0, 5) != 0) r = r - 6;
                if (r <= 1) begin
                    img[a] = OP_PUSHC; img[a + 1] = 8'($urandom); a += 2; d++;
                end else if (r <= 3) begin
                    img[a] = OP_PUSH; img[a + 1] = 8'hF0 + 8'($urandom_range(0, 15)); a += 2; d++;
                end else if (r <= 5) begin
                    img[a] = OP_POP; img[a + 1] = 8'hF0 + 8'($urandom_range(0, 15)); a += 2; d--;
                end else if (r <= 7) begin
                    img[a] = OP_ADD; a += 1; d--;
                end else if (r == 8) begin
                    img[a] = OP_SUB; a += 1; d--;
                end else begin
                    img[a] = ($urandom_range(0, 3) == 0) ? 8'h09 : OP_SUB; a += 1; d--;
                end
            end
            img[a] = OP_FINISH;
            sel = ((k % 2) == 1);
            applyReset();
            modelRun(sel ? FLOOR_HI : FLOOR_DEF);
            runDut(cyc, wr);
            checks++;
            if (cyc !== refCycles || wr !== refWrites)
                begin errors++; $display("[TB] FAIL rand%0d_timing: got cycles=%0d writes=%0d expected %0d/%0d", k, cyc, wr, refCycles, refWrites); end
            checks++;
            if ((sel ? sp1 : sp0) !== refSp || (sel ? pc1 : pc0) !== refPc)
                begin errors++; $display("[TB] FAIL rand%0d_regs: got sp=%h pc=%h expected %h/%h", k, sel ? sp1 : sp0, sel ? pc1 : pc0, refSp, refPc); end
            checks++;
            if ((sel ? error1 : error0) !== refErr || (sel ? halted1 : halted0) !== 1'b1)
                begin errors++; $display("[TB] FAIL rand%0d_flags: got err=%b halt=%b expected %b/1", k, sel ? error1 : error0, sel ? halted1 : halted0, refErr); end
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                if ((sel ? mem1[i] : mem0[i]) !== refMem[i]) bad++;
            end
            checks++;
            if (bad !== 0) begin errors++; $display("[TB] FAIL rand%0d_memory: got %0d differing bytes expected 0", k, bad); end
        end
    endtask

    initial begin
        resetN  = 1'b0;
        runReq  = 1'b0;
        sel     = 1'b0;
        loadReq = 1'b0;
        for (int i = 0; i < 7; i++) inport[i] = 8'h00;
        test_reset();
        test_boot();
        test_run_pulse();
        test_empty_add();
        test_bad_opcode();
        test_floor();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/stack_cpu_ctrl.md
# stack_cpu_ctrl

Control unit of the 8-bit stack processor: fetches, decodes and executes the stack instruction set by sequencing the single-port 256-byte program/data memory. The memory's I/O map is F8 output and F9–FF inputs. The block owns PC and SP and keeps the operand stack in RAM. It is the only master on the memory port, which writes and reads on the falling clock edge.

## Interface
Parameters:
- SP_INIT, 8'hEF: empty-stack SP; the first push goes to this address; the stack grows down.
- STACK_FLOOR, 8'hC0: lowest legal stack slot.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- resetN, in, 1: reset, asynchronous, active-low.
- run, in, 1: start request; sampled only in IDLE.
- mem_rdata, in, 8: memory read data.
- mem_addr, out, 8: memory address.
- mem_rwN, out, 1: 1 = read, 0 = write.
- mem_wdata, out, 8: memory write data.
- pc, out, 8: program counter.
- sp, out, 8: stack pointer; points to the next free slot.
- busy, out, 1: high in every state except IDLE, HALT and ERROR.
- halted, out, 1: high in HALT and ERROR.
- error, out, 1: high in ERROR.

## Operation
- Opcodes:
  - 00 PUSHC imm: push imm.
  - 01 PUSH a: push [a].
  - 02 POP a: [a] ← pop.
  - 06 ADD: push T+N.
  - 07 SUB: push T−N, where T is the top and N is the second entry.
  - 0F FINISH: go to HALT.
  - Both ADD and SUB pop T and N first; results are mod 256.
- Internal registers: IR, OPR (operand/address), TMP (data).
- Memory outputs are combinational from state and internal registers only; there is no path from mem_rdata.
- The read issued in state S is captured on the rising edge leaving S.
- States and the memory access each state drives:
  - IDLE: rd [PC]. Goes to FETCH when run=1.
  - FETCH: rd [PC]. Exit: IR←rdata, PC←PC+1.
  - DECODE: rd [PC] (speculative operand). Exit: OPR←rdata. For 00/01/02, PC←PC+1. Next state:
    - 00 → PUSH_WR.
    - 01 → LOAD.
    - 02 → POP_RD.
    - 06/07 → ALU_T.
    - 0F → HALT.
    - any other opcode → ERROR.
  - LOAD: rd [OPR]. Exit: OPR←rdata → PUSH_WR.
  - PUSH_WR: wr [SP]=OPR. Exit: SP←SP−1 → FETCH.
  - POP_RD: rd [SP+1]. Exit: TMP←rdata, SP←SP+1 → POP_WR.
  - POP_WR: wr [OPR]=TMP → FETCH.
  - ALU_T: rd [SP+1]. Exit: TMP←rdata.
  - ALU_N: rd [SP+2]. Exit: TMP←TMP±rdata, SP←SP+1.
  - ALU_WR: wr [SP+1]=TMP → FETCH.
  - HALT / ERROR: rd [PC]. Terminal until reset.
- Stack checks, made in DECODE; a failing check goes to ERROR without any write:
  - Depth = SP_INIT−SP.
  - POP needs depth ≥ 1.
  - ADD/SUB need depth ≥ 2.
  - PUSHC/PUSH need SP ≥ STACK_FLOOR.
- PC wraps FF→00 without error.
- POP to F9–FF is issued normally; the memory discards it.
- Dropping run after leaving IDLE has no effect.

## Timing
- Cycles per instruction, from FETCH entry:
  - PUSHC: 3.
  - PUSH: 4.
  - POP: 4.
  - ADD/SUB: 5.
  - FINISH: 2, counting to HALT entry.
- mem_rwN=0 for exactly one cycle per write: PUSH_WR, POP_WR, ALU_WR.
- Reset values:
  - state IDLE.
  - pc=00, sp=SP_INIT.
  - mem_addr=00, mem_rwN=1, mem_wdata=00.
  - IR/OPR/TMP=00.
  - busy=0, halted=0, error=0.
- Reset mid-instruction: state goes to IDLE asynchronously and mem_rwN=1 immediately. A write whose falling edge has not yet occurred is suppressed.
- halted/error assert in the first cycle of HALT/ERROR.

## Structure
- Shared package stack_cpu_pkg holds:
  - opcode localparams OP_PUSHC, OP_PUSH, OP_POP, OP_ADD, OP_SUB, OP_FINISH;
  - the state enum;
  - I/O map constants IO_OUT=F8 and IO_IN_BASE=F9.
- No sub-module: the ALU is one add/subtract, inline.

## Test plan
- Boot program PUSHC 12, PUSHC 23, PUSH F9, ADD, POP F0, PUSH F0, PUSH F0, ADD, SUB, POP F8, FINISH, with indata1=5 and run pulsed:
  - HALT is entered exactly 43 cycles after FETCH entry;
  - F8=0x2C, F0=0x1C;
  - sp=EF, error=0.
- PUSHC 3, ADD from an empty stack → ERROR after DECODE of ADD; no write cycle; sp=EE.
- Opcode 0x05 at address 0 → ERROR 2 cycles after FETCH; pc=01; halted=1, error=1.
- With STACK_FLOOR=EE, three PUSHC → the third goes to ERROR with sp=ED and no third write.
- resetN pulsed low during ALU_WR → mem_rwN=1 immediately; after release pc=00, sp=SP_INIT, IDLE until run.
- run held 1 for one cycle, then 0 → the program still completes to HALT; run asserted again in HALT has no effect.
